uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Sequences and shares the serial byte transmitter between two packet requesters: the command-response path (A) and the periodic sensor stream (B). Each request carries a fixed-length multi-byte packet. The block grants one requester with round-robin fairness and feeds the packet to the transmitter one byte at a time. It paces `tx_start` pulses by a fixed frame length, because the transmitter provides no completion flag. It sits between the protocol logic and the transmitter, in the 115200 Hz clock domain.

## Interface
Parameters:
- `BYTES`, 2: bytes per packet, legal range 1..4.
- `FRAME_CYCLES`, 12: clock cycles between successive `tx_start` pulses; minimum legal value 11.
- `GAP_CYCLES`, 1: idle cycles after the last byte of a packet, before `done_*` is pulsed.

Ports:
- `clk_115200hz`  in  1  bit clock; all logic is on its rising edge.
- `reset`  in  1  reset, asynchronous and active-low (0 = reset).
- `req_a`  in  1  level request from requester A; held until `grant_a`.
- `data_a`  in  8*BYTES  packet A; must be valid while `req_a` is high.
- `req_b`  in  1  level request from requester B; held until `grant_b`.
- `data_b`  in  8*BYTES  packet B.
- `grant_a`, `grant_b`  out  1 each  one-cycle pulse; packet latched.
- `done_a`, `done_b`  out  1 each  one-cycle pulse; packet fully sent.
- `busy`  out  1  high from grant until the `done_*` cycle, inclusive.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  8  byte to the transmitter; held stable for the whole frame.

## Operation
- States: IDLE, FRAME, GAP.
- Reset (asynchronous, `reset`=0): state=IDLE, all pulses=0, `busy`=0, `tx_data`=8'h00, byte index=0, cycle counter=0, round-robin pointer favours A.
- IDLE, no request pending: all outputs hold at idle values; `tx_data` keeps its last value.
- IDLE, a request pending, on the edge:
  - Choose the winner (see arbitration).
  - Latch its packet; assert `grant_x`=1 and `busy`=1.
  - Set `tx_data` = latched packet bits [8*BYTES-1 : 8*BYTES-8] (MSB byte first); set `tx_start`=1.
  - Clear counter and byte index; go to FRAME.
- Arbitration:
  - Only one requester: that one wins.
  - Both requesting: the one not served last wins.
  - The pointer updates on every grant.
  - Reset pointer state: A wins the first tie.
- FRAME:
  - The counter increments every cycle.
  - When counter = FRAME_CYCLES-1 and a byte remains: load the next lower byte into `tx_data`, pulse `tx_start`, clear the counter, increment the byte index.
  - When counter = FRAME_CYCLES-1 and no byte remains: clear the counter and go to GAP.
- GAP:
  - Wait until counter = GAP_CYCLES-1.
  - Then, for one cycle: pulse `done_x` for the granted requester, with `busy` still 1.
  - Return to IDLE.
- Requests arriving while `busy`=1 are not sampled; they wait, because requests are level-held.
- Packet data changes after the grant have no effect.
- Reset mid-packet aborts immediately: no `done_*` pulse. The system resets the transmitter together with this block.

## Timing
- Grant latency: request high before edge n gives `grant_x`, the first `tx_start`, and the first `tx_data` valid in cycle n.
- `tx_start` pulses occur at cycles n, n+FRAME_CYCLES, …, n+(BYTES-1)·FRAME_CYCLES.
- `done_x` occurs in cycle n + BYTES·FRAME_CYCLES + GAP_CYCLES.
- `busy` falls in the following cycle.
- Back-to-back packets: a request held across the `done` cycle is granted in the cycle after `done`. Minimum packet spacing is BYTES·FRAME_CYCLES + GAP_CYCLES + 1 cycles.
- `tx_data` is stable from each `tx_start` until the next load, so the transmitter can read bits live during its data phase.
- FRAME_CYCLES ≥ 11 guarantees the transmitter has returned to its start state (start, 8 data, stop-drive, stop) before the next pulse.
- Widths:
  - Counter width: clog2(max(FRAME_CYCLES, GAP_CYCLES)) + 1.
  - Byte index width: 2 bits.
  - Counters never wrap in normal operation.

## Test plan
- Reset: hold `reset`=0 with `req_a`=1 → all pulses 0, `busy`=0, `tx_data`=8'h00. After release, `grant_a` appears on the first edge.
- Single A request, `data_a`=16'hA55A, default parameters:
  - `tx_start` at cycles n and n+12 with `tx_data`=8'hA5, then 8'h5A.
  - `done_a` at n+25.
  - `busy` high for n..n+25.
- Simultaneous `req_a`=`req_b`=1, held continuously → grants alternate A, B, A, B. Each `done` is followed one cycle later by the next grant.
- `req_b` raised mid-A-packet → no `grant_b` until the cycle after `done_a`. The transmitted bytes are exactly A's latched packet, even if `data_a` changes after the grant.
- Reset asserted at counter=5 of byte 2 → outputs return to reset values asynchronously, with no `done_a`. After release, a pending `req_b` is granted first if A was last served.
- Parameter sweep BYTES=1, FRAME_CYCLES=11, GAP_CYCLES=3: one `tx_start`, then `done` at n+14. A reference transmitter model captures the correct serial byte.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one byte-serial UART transmitter between a
// command-response requester (A) and a sensor-stream requester (B).
module uart_tx_scheduler #(
    parameter int BYTES        = 2,
    parameter int FRAME_CYCLES = 12,
    parameter int GAP_CYCLES   = 1
) (
    input  logic               clk_115200hz,
    input  logic               reset,
    input  logic               req_a,
    input  logic [8*BYTES-1:0] data_a,
    input  logic               req_b,
    input  logic [8*BYTES-1:0] data_b,
    output logic               grant_a,
    output logic               grant_b,
    output logic               done_a,
    output logic               done_b,
    output logic               busy,
    output logic               tx_start,
    output logic [7:0]         tx_data
);

    localparam int PKT_W   = 8 * BYTES;
    localparam int CNT_MAX = (FRAME_CYCLES > GAP_CYCLES) ? FRAME_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [1:0]       IDX_LAST   = 2'(BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FRAME = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Bytes leave MSB first, so the byte on the wire is always the top byte.
    function automatic logic [7:0] top_byte(input logic [PKT_W-1:0] pkt);
        return pkt[PKT_W-1 -: 8];
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_next_s;
    logic [1:0]         idx_r;
    logic [1:0]         idx_next_s;
    logic [PKT_W-1:0]   pkt_r;
    logic [PKT_W-1:0]   pkt_next_s;
    logic               sel_b_r;
    logic               sel_b_next_s;
    logic               prio_b_r;
    logic               prio_b_next_s;

    logic               grant_a_next_s;
    logic               grant_b_next_s;
    logic               done_a_next_s;
    logic               done_b_next_s;
    logic               busy_next_s;
    logic               tx_start_next_s;
    logic [7:0]         tx_data_next_s;

    logic               win_b_s;
    logic [PKT_W-1:0]   pick_s;
    logic [PKT_W-1:0]   pkt_shift_s;

    // prio_b_r is set after A is served, so B wins the next tie.
    assign win_b_s     = req_b && (!req_a || prio_b_r);
    assign pick_s      = win_b_s ? data_b : data_a;
    assign pkt_shift_s = pkt_r << 4'd8;

    // State register.
    always_ff @(posedge clk_115200hz or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, datapath and output-pulse decode.
    always_comb begin
        state_next_s    = state_r;
        cnt_next_s      = cnt_r;
        idx_next_s      = idx_r;
        pkt_next_s      = pkt_r;
        sel_b_next_s    = sel_b_r;
        prio_b_next_s   = prio_b_r;
        grant_a_next_s  = 1'b0;
        grant_b_next_s  = 1'b0;
        done_a_next_s   = 1'b0;
        done_b_next_s   = 1'b0;
        tx_start_next_s = 1'b0;
        tx_data_next_s  = tx_data;
        busy_next_s     = busy;

        case (state_r)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    pkt_next_s      = pick_s;
                    tx_data_next_s  = top_byte(pick_s);
                    tx_start_next_s = 1'b1;
                    grant_a_next_s  = !win_b_s;
                    grant_b_next_s  = win_b_s;
                    sel_b_next_s    = win_b_s;
                    prio_b_next_s   = !win_b_s;
                    busy_next_s     = 1'b1;
                    cnt_next_s      = CNT_ZERO;
                    idx_next_s      = 2'd0;
                    state_next_s    = ST_FRAME;
                end else begin
                    busy_next_s     = 1'b0;
                end
            end
            ST_FRAME: begin
                if (cnt_r == FRAME_LAST) begin
                    cnt_next_s = CNT_ZERO;
                    if (idx_r < IDX_LAST) begin
                        pkt_next_s      = pkt_shift_s;
                        tx_data_next_s  = top_byte(pkt_shift_s);
                        tx_start_next_s = 1'b1;
                        idx_next_s      = idx_r + 2'd1;
                    end else begin
                        state_next_s    = ST_GAP;
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            ST_GAP: begin
                // busy stays high through the done cycle; IDLE clears it.
                if (cnt_r == GAP_LAST) begin
                    done_a_next_s = !sel_b_r;
                    done_b_next_s = sel_b_r;
                    cnt_next_s    = CNT_ZERO;
                    state_next_s  = ST_IDLE;
                end else begin
                    cnt_next_s    = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
                idx_next_s   = 2'd0;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_115200hz or negedge reset) begin
        if (!reset) begin
            cnt_r    <= CNT_ZERO;
            idx_r    <= 2'd0;
            pkt_r    <= {PKT_W{1'b0}};
            sel_b_r  <= 1'b0;
            prio_b_r <= 1'b0;
            grant_a  <= 1'b0;
            grant_b  <= 1'b0;
            done_a   <= 1'b0;
            done_b   <= 1'b0;
            busy     <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            cnt_r    <= cnt_next_s;
            idx_r    <= idx_next_s;
            pkt_r    <= pkt_next_s;
            sel_b_r  <= sel_b_next_s;
            prio_b_r <= prio_b_next_s;
            grant_a  <= grant_a_next_s;
            grant_b  <= grant_b_next_s;
            done_a   <= done_a_next_s;
            done_b   <= done_b_next_s;
            busy     <= busy_next_s;
            tx_start <= tx_start_next_s;
            tx_data  <= tx_data_next_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a default instance (2 bytes, 12/1) and a swept
// instance (1 byte, 11/3), both checked every cycle against a timing model.
module tb_uart_tx_scheduler;

    logic        clk_115200hz = 1'b0;
    logic        reset;
    always #5 clk_115200hz = ~clk_115200hz;

    logic        req_a, req_b, grant_a, grant_b, done_a, done_b, busy, tx_start;
    logic [15:0] data_a, data_b;
    logic [7:0]  tx_data;

    logic        req_a2, req_b2, grant_a2, grant_b2, done_a2, done_b2, busy2, tx_start2;
    logic [7:0]  data_a2, data_b2, tx_data2;

    int checks = 0;
    int errors = 0;

    uart_tx_scheduler #(.BYTES(2), .FRAME_CYCLES(12), .GAP_CYCLES(1)) u_dut (
        .clk_115200hz(clk_115200hz), .reset(reset),
        .req_a(req_a), .data_a(data_a), .req_b(req_b), .data_b(data_b),
        .grant_a(grant_a), .grant_b(grant_b), .done_a(done_a), .done_b(done_b),
        .busy(busy), .tx_start(tx_start), .tx_data(tx_data)
    );

    uart_tx_scheduler #(.BYTES(1), .FRAME_CYCLES(11), .GAP_CYCLES(3)) u_dut2 (
        .clk_115200hz(clk_115200hz), .reset(reset),
        .req_a(req_a2), .data_a(data_a2), .req_b(req_b2), .data_b(data_b2),
        .grant_a(grant_a2), .grant_b(grant_b2), .done_a(done_a2), .done_b(done_b2),
        .busy(busy2), .tx_start(tx_start2), .tx_data(tx_data2)
    );

    // Packet-level model: cycles elapsed since the grant decide every output.
    typedef struct packed {
        logic        active;
        int          rel;
        logic        win_b;
        logic        last_a;
        logic [31:0] pkt;
        logic [7:0]  txd;
    } model_t;

    model_t m1, m2;

    function automatic logic [7:0] byte_of(input logic [31:0] pkt, input int k, input int nb);
        logic [31:0] s;
        s = pkt >> (8 * (nb - 1 - k));
        return s[7:0];
    endfunction

    function automatic model_t m_next(input model_t m, input logic ra, input logic rb,
                                      input logic [31:0] da, input logic [31:0] db,
                                      input int nb, input int fc, input int gc);
        model_t r;
        int k;
        r = m;
        if (!m.active || m.rel == nb * fc + gc) begin
            if (ra || rb) begin
                r.win_b  = rb && (!ra || m.last_a);
                r.last_a = !r.win_b;
                r.pkt    = r.win_b ? db : da;
                r.active = 1'b1;
                r.rel    = 0;
            end else begin
                r.active = 1'b0;
                r.rel    = 0;
            end
        end else begin
            r.rel = m.rel + 1;
        end
        if (r.active) begin
            k = r.rel / fc;
            if (k > nb - 1) k = nb - 1;
            r.txd = byte_of(r.pkt, k, nb);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input string p, input model_t m, input int nb, input int fc, input int gc,
                             input logic ga, input logic gb, input logic dn_a, input logic dn_b,
                             input logic bs, input logic ts, input logic [7:0] td);
        int last;
        last = nb * fc + gc;
        chk({p, ".grant_a"},  32'(ga),   32'(m.active && m.rel == 0 && !m.win_b));
        chk({p, ".grant_b"},  32'(gb),   32'(m.active && m.rel == 0 && m.win_b));
        chk({p, ".done_a"},   32'(dn_a), 32'(m.active && m.rel == last && !m.win_b));
        chk({p, ".done_b"},   32'(dn_b), 32'(m.active && m.rel == last && m.win_b));
        chk({p, ".busy"},     32'(bs),   32'(m.active));
        chk({p, ".tx_start"}, 32'(ts),   32'(m.active && (m.rel % fc == 0) && (m.rel / fc < nb)));
        chk({p, ".tx_data"},  32'(td),   32'(m.txd));
    endtask

    // One clock: capture inputs seen by the edge, advance models, compare.
    task automatic step();
        logic ra1, rb1, ra2, rb2;
        logic [31:0] da1, db1, da2, db2;
        ra1 = req_a;  rb1 = req_b;  da1 = 32'(data_a);  db1 = 32'(data_b);
        ra2 = req_a2; rb2 = req_b2; da2 = 32'(data_a2); db2 = 32'(data_b2);
        @(posedge clk_115200hz);
        #1;
        if (reset) begin
            m1 = m_next(m1, ra1, rb1, da1, db1, 2, 12, 1);
            m2 = m_next(m2, ra2, rb2, da2, db2, 1, 11, 3);
        end else begin
            m1 = '0;
            m2 = '0;
        end
        check_dut("d1", m1, 2, 12, 1, grant_a, grant_b, done_a, done_b, busy, tx_start, tx_data);
        check_dut("d2", m2, 1, 11, 3, grant_a2, grant_b2, done_a2, done_b2, busy2, tx_start2, tx_data2);
    endtask

    task automatic wait_grant(input int which, input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!(which == 1 ? (grant_a || grant_b) : (grant_a2 || grant_b2)) && n < 60);
        chk(tag, 32'(which == 1 ? (grant_a || grant_b) : (grant_a2 || grant_b2)), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] cap;
        logic [7:0] sent;
        int n;
        m1 = '0;
        m2 = '0;
        reset = 1'b0;
        req_a = 1'b1; req_b = 1'b0; data_a = 16'hA55A; data_b = 16'h0000;
        req_a2 = 1'b0; req_b2 = 1'b0; data_a2 = 8'h00; data_b2 = 8'h00;

        // Reset held with a pending request: everything stays quiet.
        repeat (3) step();
        chk("reset.tx_data", 32'(tx_data), 32'h00);
        reset = 1'b1;
        step();
        chk("first_grant_a", 32'(grant_a), 32'd1);
        req_a = 1'b0;
        data_a = 16'h1234;

        // Single A packet: A5 then 5A, done at n+25.
        for (int i = 1; i <= 25; i++) begin
            step();
            if (i == 12) chk("second_byte", 32'(tx_data), 32'h5A);
        end
        chk("done_a_at_25", 32'(done_a), 32'd1);
        chk("busy_at_25", 32'(busy), 32'd1);
        step();
        chk("busy_falls", 32'(busy), 32'd0);
        repeat (3) step();

        // Both held continuously: grants alternate, back-to-back.
        req_a = 1'b1; req_b = 1'b1;
        data_a = 16'hC3D4; data_b = 16'hE5F6;
        repeat (4 * 26 + 1) step();
        req_a = 1'b0; req_b = 1'b0;
        repeat (30) step();

        // B arrives mid-A; A's latched bytes survive a data change.
        req_a = 1'b1; data_a = 16'($urandom);
        wait_grant(1, "a_grant_mid");
        req_a = 1'b0; data_a = 16'($urandom);
        repeat (5) step();
        req_b = 1'b1; data_b = 16'($urandom);
        n = 0;
        while (!done_a && n < 40) begin step(); n++; end
        chk("done_a_seen", 32'(done_a), 32'd1);
        step();
        chk("b_after_done_a", 32'(grant_b), 32'd1);
        req_b = 1'b0;
        repeat (30) step();

        // Reset at counter 5 of byte 2 aborts the packet.
        req_a = 1'b1; data_a = 16'($urandom);
        wait_grant(1, "a_grant_rst");
        req_a = 1'b0;
        repeat (17) step();
        req_b = 1'b1; data_b = 16'($urandom);
        reset = 1'b0;
        #1;
        m1 = '0;
        m2 = '0;
        chk("async.busy", 32'(busy), 32'd0);
        chk("async.tx_data", 32'(tx_data), 32'h00);
        chk("async.tx_start", 32'(tx_start), 32'd0);
        chk("async.done_a", 32'(done_a), 32'd0);
        repeat (2) step();
        reset = 1'b1;
        step();
        chk("b_first_after_reset", 32'(grant_b), 32'd1);
        req_b = 1'b0;
        repeat (30) step();

        // Swept instance: one byte, serial capture by a transmitter model.
        sent = 8'($urandom);
        req_a2 = 1'b1; data_a2 = sent;
        wait_grant(2, "d2_grant");
        req_a2 = 1'b0; data_a2 = ~sent;
        cap = 8'h00;
        for (int i = 0; i < 8; i++) begin
            step();
            cap[i] = tx_data2[i];
        end
        chk("d2.serial_byte", 32'(cap), 32'(sent));
        n = 8;
        while (!done_a2 && n < 30) begin step(); n++; end
        chk("d2.done_latency", 32'(n), 32'd14);
        repeat (3) step();

        // Randomized requests on both instances, held until granted.
        for (int c = 0; c < 600; c++) begin
            step();
            if (m1.active && m1.rel == 0 && !m1.win_b) begin
                req_a = 1'($urandom_range(0, 1)); data_a = 16'($urandom);
            end else if (!req_a && $urandom_range(0, 3) == 0) begin
                req_a = 1'b1; data_a = 16'($urandom);
            end
            if (m1.active && m1.rel == 0 && m1.win_b) begin
                req_b = 1'($urandom_range(0, 1)); data_b = 16'($urandom);
            end else if (!req_b && $urandom_range(0, 3) == 0) begin
                req_b = 1'b1; data_b = 16'($urandom);
            end
            if (m2.active && m2.rel == 0 && !m2.win_b) begin
                req_a2 = 1'($urandom_range(0, 1)); data_a2 = 8'($urandom);
            end else if (!req_a2 && $urandom_range(0, 3) == 0) begin
                req_a2 = 1'b1; data_a2 = 8'($urandom);
            end
            if (m2.active && m2.rel == 0 && m2.win_b) begin
                req_b2 = 1'($urandom_range(0, 1)); data_b2 = 8'($urandom);
            end else if (!req_b2 && $urandom_range(0, 3) == 0) begin
                req_b2 = 1'b1; data_b2 = 8'($urandom);
            end
        end
        req_a = 1'b0; req_b = 1'b0; req_a2 = 1'b0; req_b2 = 1'b0;
        repeat (60) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
